// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit feeder: byte width, default sizing and FSM encoding.
`timescale 1ns/1ps
package uart_pkg;

    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned DEPTH_DEF       = 16;
    localparam int unsigned ACK_TIMEOUT_DEF = 4096;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StSend     = 2'd1,
        StWaitDone = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with wrap-bit pointers; full/empty/level are decoded combinationally from the pointers.
`timescale 1ns/1ps
module byte_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [BYTE_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [BYTE_W-1:0] rd_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [AW:0]       level_o
);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              push, pop;

    always_comb begin
        full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty_o = (wr_ptr_q == rd_ptr_q);
        level_o = wr_ptr_q - rd_ptr_q;
        // Both decisions use pre-edge status, so a push while full is lost even alongside a pop.
        push     = wr_en_i && !full_o;
        pop      = rd_en_i && !empty_o;
        wr_ptr_d = push ? wr_ptr_q + (AW + 1)'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + (AW + 1)'(1) : rd_ptr_q;
        rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Presents buffered bytes to a UART transmitter and holds each one until the transmitter goes busy.
`timescale 1ns/1ps
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH       = DEPTH_DEF,
    parameter int unsigned AW          = $clog2(DEPTH),
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [BYTE_W-1:0] wr_data_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [AW:0]       level_o,
    output logic [BYTE_W-1:0] din_byte_o,
    output logic              din_rdy_o,
    input  logic              uart_ready_i,
    input  logic              clr_err_i,
    output logic              overflow_o,
    output logic              ack_err_o
);

    localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

    feeder_state_e     state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic              rdy_q, rdy_d;
    logic              overflow_q, overflow_d;
    logic              ack_err_q, ack_err_d;
    logic              pop, timeout;
    logic              fifo_full, fifo_empty;
    logic [BYTE_W-1:0] fifo_rd_data;

    byte_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (wr_en_i),
        .wr_data_i (wr_data_i),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (level_o)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        byte_d  = byte_q;
        rdy_d   = rdy_q;
        pop     = 1'b0;
        timeout = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty && uart_ready_i) begin
                    pop     = 1'b1;
                    byte_d  = fifo_rd_data;
                    rdy_d   = 1'b1;
                    timer_d = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (!uart_ready_i) begin
                    rdy_d   = 1'b0;
                    state_d = StWaitDone;
                end else if (timer_q == TIMER_LAST) begin
                    // Transmitter never took the byte; discard it rather than stall the stream.
                    rdy_d   = 1'b0;
                    timeout = 1'b1;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StWaitDone: begin
                if (uart_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                rdy_d   = 1'b0;
                state_d = StIdle;
            end
        endcase
        // A new error event outranks a same-cycle clear.
        overflow_d = (overflow_q && !clr_err_i) || (wr_en_i && fifo_full);
        ack_err_d  = (ack_err_q && !clr_err_i) || timeout;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            byte_q     <= '0;
            rdy_q      <= 1'b0;
            overflow_q <= 1'b0;
            ack_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            byte_q     <= byte_d;
            rdy_q      <= rdy_d;
            overflow_q <= overflow_d;
            ack_err_q  <= ack_err_d;
        end
    end

    assign full_o     = fifo_full;
    assign empty_o    = fifo_empty;
    assign din_byte_o = byte_q;
    assign din_rdy_o  = rdy_q;
    assign overflow_o = overflow_q;
    assign ack_err_o  = ack_err_q;

endmodule
